// File: rtl/peg_l2_pkg.sv
// Shared definitions for the L2 MAC TX path: framer states, preamble/SFD bytes
// and the reflected CRC-32 constants.
package peg_l2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Register value left after running the CRC over a frame plus its own FCS.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam logic [10:0] CNT_MAX       = 11'd2047;

endpackage

// File: rtl/peg_l2_crc32_byte.sv
// Combinational next-state of the reflected CRC-32 register for one input byte,
// processed LSB first.
module peg_l2_crc32_byte
    import peg_l2_pkg::*;
(
    input  logic [7:0]  i_data,
    input  logic [31:0] i_crc,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ i_data[i])
                w_crc = (w_crc >> 1) ^ CRC_POLY;
            else
                w_crc = w_crc >> 1;
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/peg_l2_mac_tx_framer.sv
// Ethernet TX framer: prepends preamble/SFD, passes DA..payload through, optionally
// pads to MIN_FRAME_LEN (macro PEG_L2_MAC_TX_PAD_EN) and appends the CRC-32 FCS.
module peg_l2_mac_tx_framer
    import peg_l2_pkg::*;
#(
    parameter int PKT_DATA_W    = 8,
    parameter int PKT_SIZE_W    = 16,
    parameter int MIN_FRAME_LEN = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_error,
    input  logic [PKT_DATA_W-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_error,
    output logic [PKT_DATA_W-1:0] out_data,
    output logic [PKT_SIZE_W-1:0] out_size,
    input  logic                  out_ready
);

    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 2047) begin : g_min_len_check
        $error("MIN_FRAME_LEN must fit the 11-bit byte counter");
    end

    tx_state_t   r_state;
    logic [2:0]  r_idx;
    logic [10:0] r_cnt;
    logic [31:0] r_crc;
    logic        r_err;

    logic        w_in_xfer;
    logic [7:0]  w_crc_byte;
    logic [31:0] w_crc_next;
    logic [10:0] w_cnt_inc;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    assign w_in_xfer  = in_valid & in_ready;
    // Pad bytes are zero, so only DATA feeds real input into the CRC.
    assign w_crc_byte = (r_state == ST_DATA) ? in_data[7:0] : 8'h00;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 11'd1;
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_idx[1:0], 3'b000} +: 8];

`ifdef PEG_L2_MAC_TX_PAD_EN
    logic [10:0] w_min_len;
    assign w_min_len = 11'(MIN_FRAME_LEN);
`endif

    peg_l2_crc32_byte u_crc (
        .i_data (w_crc_byte),
        .i_crc  (r_crc),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_crc   <= CRC_INIT;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    r_cnt <= '0;
                    r_crc <= CRC_INIT;
                    r_err <= 1'b0;
                    if (in_valid && in_sop)
                        r_state <= ST_PRE;
                end
                ST_PRE: if (out_ready) begin
                    if (r_idx == 3'(PREAMBLE_LEN - 1)) begin
                        r_idx   <= '0;
                        r_state <= ST_SFD;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_SFD: if (out_ready) r_state <= ST_DATA;
                ST_DATA: if (w_in_xfer) begin
                    r_crc <= w_crc_next;
                    r_cnt <= w_cnt_inc;
                    // The first DATA word is the SOP that opened the frame; any later SOP is a framing error.
                    if (in_error || (in_sop && r_cnt != 11'd0))
                        r_err <= 1'b1;
                    if (in_eop) begin
`ifdef PEG_L2_MAC_TX_PAD_EN
                        r_state <= (w_cnt_inc < w_min_len) ? ST_PAD : ST_FCS;
`else
                        r_state <= ST_FCS;
`endif
                    end
                end
`ifdef PEG_L2_MAC_TX_PAD_EN
                ST_PAD: if (out_ready) begin
                    r_crc <= w_crc_next;
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= w_min_len)
                        r_state <= ST_FCS;
                end
`endif
                ST_FCS: if (out_ready) begin
                    if (r_idx == 3'd3) begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_error = 1'b0;
        out_data  = '0;
        in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = ~in_sop;
            ST_PRE: begin
                out_valid = 1'b1;
                out_sop   = (r_idx == 3'd0);
                out_data  = PKT_DATA_W'(PREAMBLE_BYTE);
            end
            ST_SFD: begin
                out_valid = 1'b1;
                out_data  = PKT_DATA_W'(SFD_BYTE);
            end
            ST_DATA: begin
                out_valid = in_valid;
                out_data  = in_data;
                in_ready  = out_ready;
            end
`ifdef PEG_L2_MAC_TX_PAD_EN
            ST_PAD: out_valid = 1'b1;
`endif
            ST_FCS: begin
                out_valid = 1'b1;
                out_data  = PKT_DATA_W'(w_fcs_byte);
                out_eop   = (r_idx == 3'd3);
                out_error = (r_idx == 3'd3) & r_err;
            end
            default: ;
        endcase
    end

    assign out_size = out_valid ? PKT_SIZE_W'(PKT_DATA_W) : '0;

endmodule

// File: doc/peg_l2_mac_tx_framer.md
PEG_L2_MAC_TX_FRAMER -- requirements
Module: peg_l2_mac_tx_framer

Interface
REQ-001 SHALL have parameter PKT_DATA_W, default 8, packet data width in bits.
REQ-002 SHALL have parameter PKT_SIZE_W, default 16, width of the size field.
REQ-003 SHALL have parameter MIN_FRAME_LEN, default 60, minimum DA..payload byte count before FCS.
REQ-004 SHALL have port clk  input  1  single clock; rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports in_valid/in_sop/in_eop/in_error  input  1 each  frame from TX buffer (DA to last payload byte).
REQ-007 SHALL have ports in_data  input  PKT_DATA_W and in_ready  output  1.
REQ-008 SHALL have ports out_valid/out_sop/out_eop/out_error  output  1 each  framed stream toward RS TX.
REQ-009 SHALL have ports out_data  output  PKT_DATA_W, out_size  output  PKT_SIZE_W (valid bits in current word), and out_ready  input  1.

Function
REQ-010 SHALL transfer a word on either side only when valid and ready are both high in the same cycle.
REQ-011 SHALL implement FSM IDLE, PRE, SFD, DATA, PAD, FCS, advancing only on output transfers.
REQ-012 In IDLE SHALL hold out_valid=0 and in_ready=1 while in_sop=0, discarding non-SOP input words.
REQ-013 IDLE SHALL move to PRE when in_valid&in_sop, holding in_ready=0 so the SOP word is not consumed.
REQ-014 PRE SHALL emit 7 words of 0x55, out_sop=1 on the first only, then go to SFD.
REQ-015 SFD SHALL emit one 0xD5 word, then go to DATA.
REQ-016 DATA SHALL pass through combinationally: out_valid=in_valid, out_data=in_data, in_ready=out_ready, zero latency.
REQ-017 SHALL count DATA/PAD bytes in an 11-bit counter, saturating at 2047.
REQ-018 On in_eop transfer SHALL go to PAD if count<MIN_FRAME_LEN, else to FCS.
REQ-019 PAD SHALL emit 0x00 words until count==MIN_FRAME_LEN, then go to FCS.
REQ-020 SHALL compute CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final inversion) over every DATA and PAD byte.
REQ-021 FCS SHALL emit 4 CRC bytes, least-significant byte first, out_eop=1 on the fourth, then return to IDLE.
REQ-022 out_size SHALL be PKT_DATA_W on every valid word.
REQ-023 SHALL latch an error flag on in_error transfer or on in_sop seen in DATA, clear it in IDLE, and drive out_error=flag on the out_eop word.
REQ-024 in_sop inside DATA SHALL be forwarded as ordinary data.
REQ-025 When out_ready=0 all outputs and FSM state SHALL hold stable.

Reset
REQ-026 rst SHALL force IDLE, counters 0, CRC 0xFFFFFFFF, error flag 0, out_valid/out_sop/out_eop/out_error 0, out_data 0.
REQ-027 Reset mid-frame SHALL abort without emitting FCS; the next frame starts from IDLE.

Configuration
REQ-028 With macro PEG_L2_MAC_TX_PAD_EN defined, PAD state and REQ-018/019 padding SHALL be compiled in.
REQ-029 Without PEG_L2_MAC_TX_PAD_EN, DATA SHALL go directly to FCS on in_eop and short frames SHALL be sent unpadded.

Structure
REQ-030 FSM enum, preamble/SFD constants, CRC polynomial/init/residue SHALL live in shared package peg_l2_pkg.
REQ-031 Per-byte CRC update SHALL be sub-module peg_l2_crc32_byte (combinational next-CRC from byte and current CRC).

Verification
REQ-032 64-byte frame, out_ready=1 -> 7x0x55, 0xD5, 64 bytes, 4 FCS bytes; 76 words, sop on word 0, eop on word 75.
REQ-033 10-byte frame, PAD_EN defined -> 50 zero bytes inserted, 72 words total, FCS matches reference CRC of 60 bytes.
REQ-034 10-byte frame, PAD_EN undefined -> 22 words total, FCS over 10 bytes.
REQ-035 Random out_ready toggling on 100-byte frame -> byte sequence identical to REQ-032 style run, no drop or duplicate.
REQ-036 in_error on byte 20 of 64 -> out_error=1 only on eop word; next clean frame out_error=0.
REQ-037 rst asserted during DATA byte 30 -> outputs 0 next cycle; subsequent 64-byte frame correct with valid FCS.
